palette_bank_ctrl: RTL and testbench

// - Writable, multi-bank colour palette between the sprite/background index compositor and the VGA output stage.
// - CPU (Avalon-MM slave) loads NUM_BANKS palettes of 2**IDX_W entries and selects the active bank; the bank swap takes effect at the next frame start.
// - Pixel path: index -> RGB in 2 cycles, with transparency-key detect and a global saturating fade.

---
 rtl/palette_pkg.sv | 28 ++
 rtl/palette_dpram.sv | 26 ++
 rtl/palette_bank_ctrl.sv | 160 ++++++++++++++++
 tb/tb_palette_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types, control-register offsets and the saturating fade helper
// for the multi-bank colour palette.
package palette_pkg;

  localparam int PAL_IDX_W     = 8;
  localparam int PAL_COLOR_W   = 4;
  localparam int PAL_NUM_BANKS = 4;

  // Word offsets of the control registers (address MSB set).
  typedef enum logic [1:0] {
    REG_BANK = 2'd0,
    REG_TKEY = 2'd1,
    REG_FADE = 2'd2,
    REG_RSVD = 2'd3
  } reg_off_t;

  typedef struct packed {
    logic [PAL_COLOR_W-1:0] r;
    logic [PAL_COLOR_W-1:0] g;
    logic [PAL_COLOR_W-1:0] b;
  } rgb_t;

  // Channel minus fade, clamped at zero instead of wrapping.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 0;
  endfunction

endpackage

// File: rtl/palette_dpram.sv
// Simple dual-port palette RAM: port A CPU read/write, port B pixel read-only,
// both with a registered read. Port B reads the old word on a same-address write.
module palette_dpram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on purpose: palette contents survive RESET.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (a_re) a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/palette_bank_ctrl.sv
// Multi-bank colour palette: Avalon-MM register/RAM access, frame-synchronous
// bank commit, and a 2-cycle index -> RGB pipe with transparency key and fade.
module palette_bank_ctrl
  import palette_pkg::*;
#(
  parameter int IDX_W     = PAL_IDX_W,
  parameter int COLOR_W   = PAL_COLOR_W,
  parameter int NUM_BANKS = PAL_NUM_BANKS
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                AVL_CS,
  input  logic                                AVL_READ,
  input  logic                                AVL_WRITE,
  input  logic [$clog2(NUM_BANKS)+IDX_W:0]    AVL_ADDR,
  input  logic [31:0]                         AVL_WRITEDATA,
  output logic [31:0]                         AVL_READDATA,
  input  logic                                frame_start,
  input  logic                                pix_valid_in,
  input  logic [IDX_W-1:0]                    pix_index,
  output logic                                pix_valid_out,
  output logic                                pix_transparent,
  output logic [COLOR_W-1:0]                  red,
  output logic [COLOR_W-1:0]                  green,
  output logic [COLOR_W-1:0]                  blue
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int RAM_AW = BANK_W + IDX_W;
  localparam int DATA_W = 3 * COLOR_W;

  // Avalon slave without waitrequest: a strobe qualified by AVL_CS is accepted
  // in its own cycle; read data appears the next cycle and holds until the next
  // accepted read. A simultaneous read+write performs only the write.
  logic     cpu_wr, cpu_rd, sel_reg;
  reg_off_t reg_off;

  assign sel_reg = AVL_ADDR[RAM_AW];
  assign reg_off = reg_off_t'(AVL_ADDR[1:0]);
  assign cpu_wr  = AVL_CS & AVL_WRITE & ~RESET;
  assign cpu_rd  = AVL_CS & AVL_READ & ~AVL_WRITE & ~RESET;

  logic unused_wdata;
  assign unused_wdata = ^AVL_WRITEDATA;

  logic [BANK_W-1:0]  active_bank, pending_bank, bank_eff;
  logic               tkey_en;
  logic [IDX_W-1:0]   tkey;
  logic [COLOR_W-1:0] fade;

  // Committing on frame_start uses the old pending value, so a BANK write in
  // the same cycle waits for the following frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_bank  <= '0;
      pending_bank <= '0;
      tkey_en      <= 1'b0;
      tkey         <= '0;
      fade         <= '0;
    end else begin
      if (frame_start) active_bank <= pending_bank;
      if (cpu_wr && sel_reg) begin
        case (reg_off)
          REG_BANK: pending_bank <= AVL_WRITEDATA[BANK_W-1:0];
          REG_TKEY: begin
            tkey_en <= AVL_WRITEDATA[IDX_W];
            tkey    <= AVL_WRITEDATA[IDX_W-1:0];
          end
          REG_FADE: fade <= AVL_WRITEDATA[COLOR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  logic [31:0] reg_rdata;

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_BANK: reg_rdata = (32'(active_bank) << 8) | 32'(pending_bank);
      REG_TKEY: reg_rdata = 32'({tkey_en, tkey});
      REG_FADE: reg_rdata = 32'(fade);
      default:  reg_rdata = '0;
    endcase
  end

  logic [DATA_W-1:0] ram_qa, ram_qb;
  logic              rd_sel_ram;
  logic [31:0]       rd_reg_q;

  // RAM port A output only moves on an accepted RAM read, so selecting it
  // keeps READDATA stable between reads.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_sel_ram <= 1'b0;
      rd_reg_q   <= '0;
    end else if (cpu_rd) begin
      rd_sel_ram <= ~sel_reg;
      rd_reg_q   <= sel_reg ? reg_rdata : '0;
    end
  end

  assign AVL_READDATA = rd_sel_ram ? 32'(ram_qa) : rd_reg_q;

  assign bank_eff = frame_start ? pending_bank : active_bank;

  palette_dpram #(
    .ADDR_W(RAM_AW),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk     (CLK),
    .a_we    (cpu_wr & ~sel_reg),
    .a_re    (cpu_rd & ~sel_reg),
    .a_addr  (AVL_ADDR[RAM_AW-1:0]),
    .a_wdata (AVL_WRITEDATA[DATA_W-1:0]),
    .a_rdata (ram_qa),
    .b_addr  ({bank_eff, pix_index}),
    .b_rdata (ram_qb)
  );

  logic               s1_valid, s1_trans;
  logic [COLOR_W-1:0] s1_fade;

  // Key match and fade are sampled with the index so they line up with RAM data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_trans <= 1'b0;
      s1_fade  <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_trans <= tkey_en & (pix_index == tkey);
      s1_fade  <= fade;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_valid_out   <= 1'b0;
      pix_transparent <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
    end else begin
      pix_valid_out   <= s1_valid;
      pix_transparent <= s1_valid & s1_trans;
      if (s1_valid && !s1_trans) begin
        red   <= COLOR_W'(sat_sub(32'(ram_qb[3*COLOR_W-1 -: COLOR_W]), 32'(s1_fade)));
        green <= COLOR_W'(sat_sub(32'(ram_qb[2*COLOR_W-1 -: COLOR_W]), 32'(s1_fade)));
        blue  <= COLOR_W'(sat_sub(32'(ram_qb[COLOR_W-1:0]), 32'(s1_fade)));
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_palette_bank_ctrl.sv
// Self-checking bench for palette_bank_ctrl: directed table, hand sequences for
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_palette_bank_ctrl;
  import palette_pkg::*;

  localparam int IDX_W = 8, COLOR_W = 4, NUM_BANKS = 4;

  logic        CLK, RESET, AVL_CS, AVL_READ, AVL_WRITE;
  logic [10:0] AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic        frame_start, pix_valid_in, pix_valid_out, pix_transparent;
  logic [7:0]  pix_index;
  logic [3:0]  red, green, blue;

  palette_bank_ctrl #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .NUM_BANKS(NUM_BANKS)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .frame_start(frame_start),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index),
    .pix_valid_out(pix_valid_out), .pix_transparent(pix_transparent),
    .red(red), .green(green), .blue(blue)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  int          m_mem [NUM_BANKS][256];
  int          m_active, m_pending, m_tkey_en, m_tkey, m_fade;
  logic [31:0] m_rd;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] model_pix(input logic v, input int idx, input int bank);
    int c, r, g, b;
    if (!v) return 14'h0000;
    if (m_tkey_en != 0 && idx == m_tkey) return 14'h3000;
    c = m_mem[bank][idx];
    r = c / 256;
    g = (c / 16) % 16;
    b = c % 16;
    r = (r > m_fade) ? r - m_fade : 0;
    g = (g > m_fade) ? g - m_fade : 0;
    b = (b > m_fade) ? b - m_fade : 0;
    return 14'(32'h2000 + r * 256 + g * 16 + b);
  endfunction

  function automatic logic [31:0] model_read(input logic [10:0] a);
    if (!a[10]) return 32'(m_mem[a[9:8]][a[7:0]]);
    case (a[1:0])
      2'd0: return 32'(m_active * 256 + m_pending);
      2'd1: return 32'(m_tkey_en * 256 + m_tkey);
      2'd2: return 32'(m_fade);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [10:0] a, input logic [31:0] d);
    if (!a[10]) m_mem[a[9:8]][a[7:0]] = int'(d % 4096);
    else begin
      case (a[1:0])
        2'd0: m_pending = int'(d % 4);
        2'd1: begin m_tkey_en = int'(d[8]); m_tkey = int'(d % 256); end
        2'd2: m_fade = int'(d % 16);
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [13:0] e);
    check(name, 32'({pix_valid_out, pix_transparent, red, green, blue}), 32'(e));
  endtask

  // One clock cycle: score previous outputs, drive inputs, advance the model.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [10:0] a, input logic [31:0] d,
                      input logic fs, input logic pv, input logic [7:0] idx);
    logic [13:0] e;
    e = exp_q.pop_front();
    check("pix_pipe", 32'({pix_valid_out, pix_transparent, red, green, blue}), 32'(e));
    check("readdata", AVL_READDATA, m_rd);
    RESET = rst; AVL_CS = wr | rd; AVL_WRITE = wr; AVL_READ = rd;
    AVL_ADDR = a; AVL_WRITEDATA = d;
    frame_start = fs; pix_valid_in = pv; pix_index = idx;
    if (rst) begin
      m_active = 0; m_pending = 0; m_tkey_en = 0; m_tkey = 0; m_fade = 0;
      m_rd = 32'h0;
      exp_q.delete();
      exp_q.push_back(14'h0);
      exp_q.push_back(14'h0);
    end else begin
      exp_q.push_back(model_pix(pv, int'(idx), fs ? m_pending : m_active));
      if (rd && !wr) m_rd = model_read(a);
      if (fs) m_active = m_pending;
      if (wr) model_write(a, d);
    end
    @(negedge CLK);
  endtask

  function automatic logic [10:0] ent(input int b, input int i);
    return {1'b0, 2'(b), 8'(i)};
  endfunction

  function automatic logic [10:0] reg_a(input int o);
    return {1'b1, 8'h00, 2'(o)};
  endfunction

  task automatic idle();                                   step(0, 0, 0, 11'h0, 0, 0, 0, 8'h0); endtask
  task automatic wr(input logic [10:0] a, input logic [31:0] d); step(0, 1, 0, a, d, 0, 0, 8'h0); endtask
  task automatic rd(input logic [10:0] a);                 step(0, 0, 1, a, 0, 0, 0, 8'h0); endtask
  task automatic pix(input int idx, input logic fs);       step(0, 0, 0, 11'h0, 0, fs, 1, 8'(idx)); endtask

  typedef struct {
    logic [3:0]  fade;
    logic [8:0]  tkey;
    logic [7:0]  idx;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'd0,  9'h000, 8'd5, 14'h27A3};
    tbl[1] = '{4'd4,  9'h000, 8'd5, 14'h2360};
    tbl[2] = '{4'd0,  9'h100, 8'd0, 14'h3000};
    tbl[3] = '{4'd0,  9'h100, 8'd1, 14'h25C2};
    tbl[4] = '{4'd15, 9'h000, 8'd5, 14'h2000};
    tbl[5] = '{4'd2,  9'h105, 8'd5, 14'h3000};
    tbl[6] = '{4'd0,  9'h005, 8'd5, 14'h27A3};
    tbl[7] = '{4'd3,  9'h000, 8'd1, 14'h2290};

    RESET = 1'b1; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = 0;
    AVL_WRITEDATA = 0; frame_start = 0; pix_valid_in = 0; pix_index = 0;
    m_active = 0; m_pending = 0; m_tkey_en = 0; m_tkey = 0; m_fade = 0; m_rd = 0;
    exp_q.push_back(14'h0);
    exp_q.push_back(14'h0);
    repeat (3) @(negedge CLK);

    check_out("reset_pix", 14'h0);
    check("reset_rdata", AVL_READDATA, 32'h0);
    idle();
    rd(reg_a(0)); check("reset_bank", AVL_READDATA, 32'h0);
    rd(reg_a(1)); check("reset_tkey", AVL_READDATA, 32'h0);
    rd(reg_a(2)); check("reset_fade", AVL_READDATA, 32'h0);

    for (int b = 0; b < NUM_BANKS; b++)
      for (int i = 0; i < 256; i++)
        wr(ent(b, i), 32'($urandom_range(0, 4095)));
    wr(ent(1, 5), 32'h7A3);
    wr(ent(1, 1), 32'h5C2);
    wr(ent(1, 0), 32'h444);
    wr(ent(1, 9), 32'h123);
    wr(ent(2, 5), 32'h0B1);
    rd(ent(1, 1)); check("ram_readback", AVL_READDATA, 32'h5C2);

    // load + bank select
    wr(reg_a(0), 32'h1);
    rd(reg_a(0)); check("bank_pending", AVL_READDATA, 32'h001);
    step(0, 0, 0, 11'h0, 0, 1, 0, 8'h0);
    rd(reg_a(0)); check("bank_commit", AVL_READDATA, 32'h101);
    pix(5, 0);
    check("latency_t1", 32'(pix_valid_out), 32'h0);
    idle();
    check_out("load_pix", 14'h27A3);

    for (int k = 0; k < 8; k++) begin
      wr(reg_a(2), 32'(tbl[k].fade));
      wr(reg_a(1), 32'(tbl[k].tkey));
      pix(int'(tbl[k].idx), 0);
      idle();
      check_out($sformatf("table_%0d", k), tbl[k].exp);
    end
    wr(reg_a(2), 32'h0);
    wr(reg_a(1), 32'h0);

    // same-cycle CPU write and pixel read of one entry
    step(0, 1, 0, ent(1, 9), 32'hFFF, 0, 1, 8'd9);
    pix(9, 0);
    check_out("collide_old", 14'h2123);
    idle();
    check_out("collide_new", 14'h2FFF);

    // deferred swap
    wr(reg_a(0), 32'h2);
    pix(5, 0);
    idle();
    check_out("swap_deferred", 14'h27A3);
    pix(5, 1);
    idle();
    check_out("swap_on_fs", 14'h20B1);
    rd(reg_a(0)); check("bank_swapped", AVL_READDATA, 32'h202);

    // BANK write coinciding with frame_start
    step(0, 1, 0, reg_a(0), 32'h3, 1, 0, 8'h0);
    rd(reg_a(0)); check("bank_wr_fs", AVL_READDATA, 32'h203);
    step(0, 0, 0, 11'h0, 0, 1, 0, 8'h0);
    rd(reg_a(0)); check("bank_next_fs", AVL_READDATA, 32'h303);

    // simultaneous read and write: write only
    wr(reg_a(2), 32'h5);
    rd(reg_a(2)); check("fade_rd", AVL_READDATA, 32'h5);
    step(0, 1, 1, reg_a(2), 32'h7, 0, 0, 8'h0);
    check("rdwr_hold", AVL_READDATA, 32'h5);
    rd(reg_a(2)); check("rdwr_wrote", AVL_READDATA, 32'h7);

    // reset during a pixel burst
    wr(reg_a(1), 32'h1AB);
    pix(1, 0);
    pix(2, 0);
    step(1, 0, 1, reg_a(1), 0, 0, 1, 8'd3);
    check_out("rst_drop0", 14'h0);
    step(1, 1, 0, reg_a(2), 32'h9, 0, 0, 8'h0);
    check_out("rst_drop1", 14'h0);
    check("rst_rdata", AVL_READDATA, 32'h0);
    idle();
    rd(reg_a(0)); check("rst_bank", AVL_READDATA, 32'h0);
    rd(reg_a(1)); check("rst_tkey", AVL_READDATA, 32'h0);
    rd(reg_a(2)); check("rst_fade", AVL_READDATA, 32'h0);
    rd(ent(1, 5)); check("rst_ram_kept", AVL_READDATA, 32'h7A3);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           11'($urandom_range(0, 2047)),
           $urandom(),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom_range(0, 255)));
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
